// File: rtl/neopix_frame_sequencer_if.sv
// Bundle of the client write ports and the NeopixelController load/go/ready
// port of neopix_frame_sequencer.
//
//   a_valid/a_pixel/a_rgb  client A write request, target pixel, colour {r,g,b}
//   a_ready                client A write accepted this cycle
//   b_*                    same for client B
//   nc_pixel, nc_red, nc_green, nc_blue
//                          pixel index and colour presented to the controller
//   nc_load                controller latches pixel/colour
//   nc_go                  controller shifts the frame out
//   nc_ready               controller idle (1) / transmitting (0)
//
// Modport master is the sequencer side; modport slave is the clients plus
// the controller.
interface neopix_frame_sequencer_if #(
    parameter int IDX_W = 3
);
    logic             a_valid;
    logic [IDX_W-1:0] a_pixel;
    logic [23:0]      a_rgb;
    logic             a_ready;

    logic             b_valid;
    logic [IDX_W-1:0] b_pixel;
    logic [23:0]      b_rgb;
    logic             b_ready;

    logic [IDX_W-1:0] nc_pixel;
    logic [7:0]       nc_red;
    logic [7:0]       nc_green;
    logic [7:0]       nc_blue;
    logic             nc_load;
    logic             nc_go;
    logic             nc_ready;

    modport master (
        input  a_valid, a_pixel, a_rgb,
        input  b_valid, b_pixel, b_rgb,
        input  nc_ready,
        output a_ready, b_ready,
        output nc_pixel, nc_red, nc_green, nc_blue, nc_load, nc_go
    );

    modport slave (
        output a_valid, a_pixel, a_rgb,
        output b_valid, b_pixel, b_rgb,
        output nc_ready,
        input  a_ready, b_ready,
        input  nc_pixel, nc_red, nc_green, nc_blue, nc_load, nc_go
    );
endinterface

// File: rtl/neopix_frame_sequencer.sv
// neopix_frame_sequencer
//   Two game-logic clients write pixel colours into a shadow buffer. Writes
//   are arbitrated (one per cycle, round-robin when both request). Whenever a
//   pixel is dirty, the refresh interval has elapsed and the controller is
//   idle, the whole buffer is replayed into the NeopixelController (one
//   nc_load per pixel, two cycles apart) followed by nc_go, then the block
//   waits for the controller to drop and raise nc_ready again.
//
// Ports
//   CLOCK_50    system clock, all logic on posedge
//   reset_n     asynchronous active-low reset
//   bus         neopix_frame_sequencer_if.master (client writes + controller)
//   busy        FSM not in IDLE
//   frame_done  one-cycle pulse when a frame has been transmitted
//   wdog_err    sticky watchdog flag
//
// Build option
//   NEOSEQ_WDOG_EN  when defined, a watchdog bounds the time spent waiting on
//                   nc_ready; on expiry wdog_err is set, every pixel is marked
//                   dirty and the FSM returns to IDLE to retry. When undefined
//                   the waits are unbounded and wdog_err is constant 0.
module neopix_frame_sequencer #(
    parameter int NUM_PIX     = 8,
    parameter int IDX_W       = 3,
    parameter int REFRESH_CYC = 50000,
    parameter int WDOG_CYC    = 100000
) (
    input  logic                           CLOCK_50,
    input  logic                           reset_n,
    neopix_frame_sequencer_if.master       bus,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           wdog_err
);
    localparam int               CNT_W        = $clog2(REFRESH_CYC + 1);
    localparam logic [CNT_W-1:0] REFRESH_LOAD = CNT_W'(REFRESH_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_PIX - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, GAP, GO, WAIT_LO, WAIT_HI, DONE
    } state_t;

    state_t             state, state_nxt;
    logic [23:0]        pix_buf [NUM_PIX];
    logic [NUM_PIX-1:0] dirty, dirty_nxt;
    logic [CNT_W-1:0]   refresh_cnt;
    logic [IDX_W-1:0]   idx;
    logic               rr_b;          // 1: B wins the next contested cycle
    logic [IDX_W-1:0]   pix_q;
    logic [23:0]        rgb_q;

    logic               grant_a, grant_b, wr_ok;
    logic [IDX_W-1:0]   wr_pix;
    logic [23:0]        wr_rgb;
    logic               start;
    logic               wdog_trip;
    logic [IDX_W-1:0]   ld_idx;
    logic [23:0]        ld_rgb;

    // Write arbitration: a lone request always wins, a contested cycle goes
    // to the client the round-robin pointer names.
    always_comb begin
        grant_a = bus.a_valid && (!bus.b_valid || !rr_b);
        grant_b = bus.b_valid && (!bus.a_valid ||  rr_b);
        wr_pix  = grant_b ? bus.b_pixel : bus.a_pixel;
        wr_rgb  = grant_b ? bus.b_rgb   : bus.a_rgb;
        wr_ok   = (grant_a || grant_b) && (wr_pix <= LAST_IDX);
    end

    assign bus.a_ready = grant_a;
    assign bus.b_ready = grant_b;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rr_b <= 1'b0;
        end else if (bus.a_valid && bus.b_valid) begin
            rr_b <= ~rr_b;
        end
    end

    assign start = (state == IDLE) && (|dirty) && (refresh_cnt == '0) && bus.nc_ready;

    // Next-state logic; a watchdog trip overrides the waits.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = GAP;
            GAP:     state_nxt = (idx == LAST_IDX) ? GO : LOAD;
            GO:      state_nxt = WAIT_LO;
            WAIT_LO: if (!bus.nc_ready) state_nxt = WAIT_HI;
            WAIT_HI: if (bus.nc_ready) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (wdog_trip) state_nxt = IDLE;
    end

    // Pixel about to be loaded. The colour is captured on entry to LOAD and
    // forwards a write landing on the same edge, so the value held during
    // LOAD is exactly the buffer content of that cycle.
    always_comb begin
        ld_idx = (state == IDLE) ? '0 : idx + IDX_W'(1);
        ld_rgb = (wr_ok && (wr_pix == ld_idx)) ? wr_rgb : pix_buf[ld_idx];
    end

    // Dirty flags: frame start clears all, watchdog sets all, and a write
    // always marks its pixel, even on the frame-start edge.
    always_comb begin
        dirty_nxt = dirty;
        if (start)     dirty_nxt = '0;
        if (wdog_trip) dirty_nxt = '1;
        if (wr_ok)     dirty_nxt[wr_pix] = 1'b1;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            refresh_cnt <= '0;
            pix_q       <= '0;
            rgb_q       <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == LOAD) begin
                idx   <= ld_idx;
                pix_q <= ld_idx;
                rgb_q <= ld_rgb;
            end
            if (start) begin
                refresh_cnt <= REFRESH_LOAD;
            end else if (refresh_cnt != '0) begin
                refresh_cnt <= refresh_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PIX; i++) pix_buf[i] <= '0;
            dirty <= '0;
        end else begin
            if (wr_ok) pix_buf[wr_pix] <= wr_rgb;
            dirty <= dirty_nxt;
        end
    end

`ifdef NEOSEQ_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);

    logic [WD_W-1:0] wdog_cnt;
    logic            wdog_flag;
    logic            in_wait;

    assign in_wait   = (state == WAIT_LO) || (state == WAIT_HI);
    // Trips on the WDOG_CYC-th consecutive cycle spent waiting.
    assign wdog_trip = in_wait && (wdog_cnt == WD_W'(WDOG_CYC - 1));

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt  <= '0;
            wdog_flag <= 1'b0;
        end else begin
            if (in_wait && !wdog_trip) wdog_cnt <= wdog_cnt + WD_W'(1);
            else                       wdog_cnt <= '0;
            if (wdog_trip) wdog_flag <= 1'b1;
        end
    end

    assign wdog_err = wdog_flag;
`else
    assign wdog_trip = 1'b0;
    // WDOG_CYC has no effect in this build; the expression is constant 0.
    assign wdog_err  = (WDOG_CYC < 0);
`endif

    assign bus.nc_load  = (state == LOAD);
    assign bus.nc_go    = (state == GO);
    assign bus.nc_pixel = pix_q;
    assign bus.nc_red   = rgb_q[23:16];
    assign bus.nc_green = rgb_q[15:8];
    assign bus.nc_blue  = rgb_q[7:0];
    assign busy         = (state != IDLE);
    assign frame_done   = (state == DONE);

endmodule

// File: tb/tb_neopix_frame_sequencer.sv
// Testbench for neopix_frame_sequencer. A scoreboard queue holds the
// expected {pixel, colour} of every nc_load; entries are pushed from a
// reference copy of the pixel buffer when stimulus is driven and popped by a
// monitor on each nc_load. A small controller model answers nc_go by
// dropping and later raising nc_ready.
module tb_neopix_frame_sequencer;
    localparam int NUM_PIX     = 8;
    localparam int IDX_W       = 3;
    localparam int REFRESH_CYC = 200;
    localparam int WDOG_CYC    = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, frame_done, wdog_err;

    always #5 clk = ~clk;

    neopix_frame_sequencer_if #(.IDX_W(IDX_W)) ifc ();

    neopix_frame_sequencer #(
        .NUM_PIX(NUM_PIX), .IDX_W(IDX_W),
        .REFRESH_CYC(REFRESH_CYC), .WDOG_CYC(WDOG_CYC)
    ) dut (
        .CLOCK_50(clk), .reset_n(rst_n), .bus(ifc.master),
        .busy(busy), .frame_done(frame_done), .wdog_err(wdog_err)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int load_cnt = 0, go_cnt = 0, done_cnt = 0;
    logic [26:0] exp_q[$];
    logic [26:0] exp_item;
    logic [23:0] mdl [NUM_PIX];
    logic ctrl_auto = 1'b1;
    logic ctrl_lvl = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.nc_load) begin
                load_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL load_unexpected got pixel=%0d rgb=%02h%02h%02h required=no load",
                             ifc.nc_pixel, ifc.nc_red, ifc.nc_green, ifc.nc_blue);
                end else begin
                    exp_item = exp_q.pop_front();
                    if ({ifc.nc_pixel, ifc.nc_red, ifc.nc_green, ifc.nc_blue} !== exp_item) begin
                        failures++;
                        $display("FAIL load_data got pixel=%0d rgb=%02h%02h%02h required pixel=%0d rgb=%06h",
                                 ifc.nc_pixel, ifc.nc_red, ifc.nc_green, ifc.nc_blue,
                                 exp_item[26:24], exp_item[23:0]);
                    end
                end
            end
            if (ifc.nc_go) go_cnt++;
            if (frame_done) done_cnt++;
        end
    end

    // Controller model: two cycles after nc_go, ready drops for ten cycles.
    initial begin
        int dly;
        int low;
        dly = 0;
        low = 0;
        ifc.nc_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (!ctrl_auto) begin
                ifc.nc_ready = ctrl_lvl;
                dly = 0;
                low = 0;
            end else if (ifc.nc_go) begin
                dly = 2;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    ifc.nc_ready = 1'b0;
                    low = 10;
                end
            end else if (low > 0) begin
                low--;
                if (low == 0) ifc.nc_ready = 1'b1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle write request; returns the ready seen during the cycle.
    task automatic drive_wr(input bit side_b, input logic [2:0] pix,
                            input logic [23:0] rgb, output logic rdy);
        if (side_b) begin
            ifc.b_valid = 1'b1; ifc.b_pixel = pix; ifc.b_rgb = rgb;
        end else begin
            ifc.a_valid = 1'b1; ifc.a_pixel = pix; ifc.a_rgb = rgb;
        end
        #1;
        rdy = side_b ? ifc.b_ready : ifc.a_ready;
        @(posedge clk);
        #1;
        ifc.a_valid = 1'b0;
        ifc.b_valid = 1'b0;
    endtask

    task automatic push_frame();
        for (int i = 0; i < NUM_PIX; i++) exp_q.push_back({3'(i), mdl[i]});
    endtask

    function automatic bit cond_now(input int which);
        case (which)
            0: return ifc.nc_load === 1'b1;
            1: return ifc.nc_go === 1'b1;
            2: return frame_done === 1'b1;
            3: return ifc.nc_ready === 1'b0;
            4: return (ifc.nc_load === 1'b1) && (ifc.nc_pixel === 3'd4);
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_cond(input int which, input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (cond_now(which)) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        int l0, g0;
        bit busy_seen;
        rst_n = 1'b0;
        step(2);
        checks++;
        if ({ifc.nc_load, ifc.nc_go, busy, frame_done, wdog_err, ifc.nc_pixel,
             ifc.nc_red, ifc.nc_green, ifc.nc_blue} !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs got load=%b go=%b busy=%b done=%b wdog=%b pix=%0d rgb=%02h%02h%02h required all 0",
                     ifc.nc_load, ifc.nc_go, busy, frame_done, wdog_err, ifc.nc_pixel,
                     ifc.nc_red, ifc.nc_green, ifc.nc_blue);
        end
        rst_n = 1'b1;
        l0 = load_cnt;
        g0 = go_cnt;
        busy_seen = 1'b0;
        for (int k = 0; k < 2 * REFRESH_CYC; k++) begin
            step(1);
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        checks++;
        if (load_cnt != l0 || go_cnt != g0) begin
            failures++;
            $display("FAIL idle_no_frame got loads=%0d gos=%0d required 0 0", load_cnt - l0, go_cnt - g0);
        end
        checks++;
        if (busy_seen) begin
            failures++;
            $display("FAIL idle_busy got busy=1 required busy=0");
        end
    endtask

    task automatic test_single_frame();
        logic rdy;
        int bad;
        bit ok;
        mdl[3] = 24'hFF0000;
        push_frame();
        drive_wr(1'b0, 3'd3, 24'hFF0000, rdy);
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL single_a_ready got %b required 1", rdy);
        end
        checks++;
        if (ifc.nc_load !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL latency_t1 got load=%b busy=%b required 0 0", ifc.nc_load, busy);
        end
        step(1);
        checks++;
        if (ifc.nc_load !== 1'b1 || ifc.nc_pixel !== 3'd0) begin
            failures++;
            $display("FAIL latency_t2 got load=%b pixel=%0d required load=1 pixel=0", ifc.nc_load, ifc.nc_pixel);
        end
        bad = 0;
        for (int k = 1; k < 2 * NUM_PIX; k++) begin
            step(1);
            if (ifc.nc_load !== (k % 2 == 0) || ifc.nc_go !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL load_spacing got %0d bad cycles required 0", bad);
        end
        step(1);
        checks++;
        if (ifc.nc_go !== 1'b1 || ifc.nc_load !== 1'b0) begin
            failures++;
            $display("FAIL go_timing got go=%b load=%b required go=1 load=0", ifc.nc_go, ifc.nc_load);
        end
        step(1);
        checks++;
        if (ifc.nc_go !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL go_width got go=%b busy=%b required go=0 busy=1", ifc.nc_go, busy);
        end
        wait_cond(2, 100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL frame_done_timeout got no pulse in 100 cycles required pulse");
        end
        step(1);
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL frame_end got busy=%b done=%b pending=%0d required 0 0 0", busy, frame_done, exp_q.size());
        end
    endtask

    task automatic test_arbitration();
        logic [2:0] a_pix [6];
        logic [2:0] b_pix [6];
        int bad_grant, both;
        bit ok;
        a_pix = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        b_pix = '{3'd6, 3'd6, 3'd2, 3'd4, 3'd4, 3'd2};
        bad_grant = 0;
        both = 0;
        for (int i = 0; i < 6; i++) begin
            ifc.a_valid = 1'b1; ifc.a_pixel = a_pix[i]; ifc.a_rgb = 24'hA00000 | 24'(i);
            ifc.b_valid = 1'b1; ifc.b_pixel = b_pix[i]; ifc.b_rgb = 24'h00B000 | 24'(i);
            #1;
            if (ifc.a_ready && ifc.b_ready) both++;
            if (ifc.a_ready !== (i % 2 == 0) || ifc.b_ready !== (i % 2 == 1)) bad_grant++;
            if (i % 2 == 0) mdl[a_pix[i]] = 24'hA00000 | 24'(i);
            else            mdl[b_pix[i]] = 24'h00B000 | 24'(i);
            @(posedge clk);
            #1;
        end
        ifc.a_valid = 1'b0;
        ifc.b_valid = 1'b0;
        checks++;
        if (bad_grant != 0) begin
            failures++;
            $display("FAIL rr_grants got %0d wrong cycles required 0", bad_grant);
        end
        checks++;
        if (both != 0) begin
            failures++;
            $display("FAIL rr_both_ready got %0d cycles required 0", both);
        end
        push_frame();
        wait_cond(2, 400, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rr_frame_timeout got no frame_done in 400 cycles required pulse");
        end
        step(1);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rr_frame_pending got %0d loads missing required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic rdy;
        bit ok;
        int s1, s2;
        mdl[1] = 24'h000011;
        push_frame();
        drive_wr(1'b0, 3'd1, 24'h000011, rdy);
        wait_cond(0, 400, ok);
        s1 = cyc;
        wait_cond(3, 100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_wait_timeout got no ready drop required drop");
        end
        step(1);
        mdl[0] = 24'h00FF00;
        drive_wr(1'b1, 3'd0, 24'h00FF00, rdy);
        checks++;
        if (rdy !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_write_in_wait got ready=%b busy=%b required 1 1", rdy, busy);
        end
        push_frame();
        step(1);
        wait_cond(0, 400, ok);
        s2 = cyc;
        checks++;
        if (!ok || (s2 - s1) != REFRESH_CYC) begin
            failures++;
            $display("FAIL refresh_interval got %0d cycles required %0d", s2 - s1, REFRESH_CYC);
        end
        wait_cond(2, 100, ok);
        step(1);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_frame_end got done=%b pending=%0d required 1 0", ok, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic rdy;
        bit ok;
        int l0;
        bit busy_seen;
        mdl[7] = 24'h123456;
        push_frame();
        drive_wr(1'b0, 3'd7, 24'h123456, rdy);
        wait_cond(4, 400, ok);
        step(1);
        checks++;
        if (!ok || busy !== 1'b1 || ifc.nc_load !== 1'b0) begin
            failures++;
            $display("FAIL mid_gap4 got found=%b busy=%b load=%b required 1 1 0", ok, busy, ifc.nc_load);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ifc.nc_load !== 1'b0 || ifc.nc_go !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got load=%b go=%b busy=%b required 0 0 0", ifc.nc_load, ifc.nc_go, busy);
        end
        exp_q.delete();
        for (int i = 0; i < NUM_PIX; i++) mdl[i] = 24'h0;
        step(2);
        rst_n = 1'b1;
        checks++;
        if ({ifc.nc_load, ifc.nc_go, busy, frame_done, wdog_err, ifc.nc_pixel,
             ifc.nc_red, ifc.nc_green, ifc.nc_blue} !== 32'd0) begin
            failures++;
            $display("FAIL post_reset_outputs got pix=%0d rgb=%02h%02h%02h busy=%b required all 0",
                     ifc.nc_pixel, ifc.nc_red, ifc.nc_green, ifc.nc_blue, busy);
        end
        l0 = load_cnt;
        busy_seen = 1'b0;
        for (int k = 0; k < 2 * REFRESH_CYC; k++) begin
            step(1);
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        checks++;
        if (load_cnt != l0 || busy_seen) begin
            failures++;
            $display("FAIL post_reset_idle got loads=%0d busy_seen=%b required 0 0", load_cnt - l0, busy_seen);
        end
        mdl[2] = 24'h0000AA;
        push_frame();
        drive_wr(1'b1, 3'd2, 24'h0000AA, rdy);
        wait_cond(2, 100, ok);
        step(1);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            failures++;
            $display("FAIL post_reset_frame got done=%b pending=%0d required 1 0", ok, exp_q.size());
        end
    endtask

    task automatic test_watchdog();
        logic rdy;
        bit ok;
        int d0;
        ctrl_lvl = 1'b1;
        ctrl_auto = 1'b0;
        mdl[5] = 24'h050505;
        push_frame();
        drive_wr(1'b0, 3'd5, 24'h050505, rdy);
        wait_cond(1, 400, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wdog_go_timeout got no nc_go in 400 cycles required pulse");
        end
        d0 = done_cnt;
`ifdef NEOSEQ_WDOG_EN
        step(WDOG_CYC);
        checks++;
        if (wdog_err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL wdog_early got wdog=%b busy=%b required 0 1", wdog_err, busy);
        end
        step(1);
        checks++;
        if (wdog_err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wdog_trip got wdog=%b busy=%b required 1 0", wdog_err, busy);
        end
        push_frame();
        ctrl_auto = 1'b1;
        step(1);
        checks++;
        if (ifc.nc_load !== 1'b1) begin
            failures++;
            $display("FAIL wdog_retry got load=%b required 1", ifc.nc_load);
        end
        wait_cond(2, 100, ok);
        step(1);
        checks++;
        if (!ok || wdog_err !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL wdog_retry_end got done=%b wdog=%b pending=%0d required 1 1 0",
                     ok, wdog_err, exp_q.size());
        end
`else
        step(WDOG_CYC + 1);
        checks++;
        if (busy !== 1'b1 || wdog_err !== 1'b0 || done_cnt != d0) begin
            failures++;
            $display("FAIL no_wdog_wait got busy=%b wdog=%b done=%0d required 1 0 0",
                     busy, wdog_err, done_cnt - d0);
        end
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NUM_PIX; i++) mdl[i] = 24'h0;
        ctrl_auto = 1'b1;
        step(2);
`endif
    endtask

    initial begin
        ifc.a_valid = 1'b0; ifc.a_pixel = '0; ifc.a_rgb = '0;
        ifc.b_valid = 1'b0; ifc.b_pixel = '0; ifc.b_rgb = '0;
        for (int i = 0; i < NUM_PIX; i++) mdl[i] = 24'h0;
        test_reset();
        test_single_frame();
        test_arbitration();
        test_back_to_back();
        test_reset_mid_frame();
        test_watchdog();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
